// File: rtl/dpi_pkg.sv
// Shared widths, table depth, FSM state encoding and default gap lengths for the stream dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpi_pkg;

    localparam int SID_W        = 6;
    localparam int TBL_DEPTH    = 64;
    localparam int DEF_LOAD_GAP = 2;
    localparam int DEF_EOP_GAP  = 4;
    localparam int GAP_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_GAP,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP
    } dpi_state_t;

endpackage

// File: rtl/dpi_flow_table.sv
// Flow key CAM with valid bits, round-robin allocation pointer and per-stream enable mask RAM.
// Latency: lookup result is combinational; alloc and cfg writes land on the next clock edge.
// Backpressure: none; a lookup is serviced every cycle lookup_en is high.
module dpi_flow_table
    import dpi_pkg::*;
#(
    parameter int                   NUM_REGEX    = 8,
    parameter int                   KEY_W        = 32,
    parameter logic [NUM_REGEX-1:0] DEFAULT_MASK = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_en,
    input  logic [KEY_W-1:0]     lookup_key,
    output logic [SID_W-1:0]     lookup_id,
    output logic                 lookup_miss,
    input  logic [SID_W-1:0]     rd_addr,
    output logic [NUM_REGEX-1:0] rd_mask,
    input  logic                 cfg_we,
    input  logic [SID_W-1:0]     cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_mask
);

    logic [KEY_W-1:0]     key_mem  [TBL_DEPTH];
    logic [NUM_REGEX-1:0] mask_mem [TBL_DEPTH];
    logic [TBL_DEPTH-1:0] valid;
    logic [SID_W-1:0]     alloc_ptr;
    logic                 hit;
    logic [SID_W-1:0]     hit_idx;
    logic                 alloc_we;

    // Parallel compare; scanning high-to-low leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = TBL_DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (key_mem[i] == lookup_key)) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
        end
    end

    assign lookup_miss = ~hit;
    assign lookup_id   = hit ? hit_idx : alloc_ptr;
    assign alloc_we    = lookup_en & ~hit;
    assign rd_mask     = mask_mem[rd_addr];

    // Valid bits and allocation pointer; the pointer wraps and evicts the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            alloc_ptr <= '0;
        end else if (alloc_we) begin
            valid[alloc_ptr] <= 1'b1;
            alloc_ptr        <= alloc_ptr + 1'b1;
        end
    end

    // Key storage needs no reset: entries are qualified by valid.
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            key_mem[alloc_ptr] <= lookup_key;
        end
    end

    // Mask RAM keeps its contents across reset; allocation overrides a same-slot cfg write.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mask_mem[cfg_addr] <= cfg_mask;
        end
        if (alloc_we) begin
            mask_mem[alloc_ptr] <= DEFAULT_MASK;
        end
    end

endmodule

// File: rtl/dpi_stream_dispatch.sv
// Maps flow keys to stream ids and sequences load_state -> chars -> eop for the regex matchers.
// Latency: sop to load_state 3 cycles; chars 1 cycle behind the accepted byte; eop EOP_GAP+1 after last char.
// Backpressure: in_rdy only in STREAM (and for dropped non-sop beats in IDLE). Optional stats: DPI_DISPATCH_STATS_EN.
module dpi_stream_dispatch
    import dpi_pkg::*;
#(
    parameter int                   NUM_REGEX    = 8,
    parameter int                   KEY_W        = 32,
    parameter int                   LOAD_GAP     = DEF_LOAD_GAP,
    parameter int                   EOP_GAP      = DEF_EOP_GAP,
    parameter logic [NUM_REGEX-1:0] DEFAULT_MASK = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_vld,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [KEY_W-1:0]     in_key,
    output logic                 in_rdy,
    input  logic                 cfg_we,
    input  logic [SID_W-1:0]     cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_mask,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic                 load_state,
    output logic [SID_W-1:0]     stream_id,
    output logic                 new_stream_id,
    output logic [NUM_REGEX-1:0] enable
`ifdef DPI_DISPATCH_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [31:0]          stat_miss
`endif
);

    dpi_state_t           state, state_nxt;
    logic [GAP_CNT_W-1:0] cnt, cnt_nxt;
    logic [KEY_W-1:0]     key_q;
    logic [SID_W-1:0]     lk_id;
    logic                 lk_new;
    logic [SID_W-1:0]     tbl_id;
    logic                 tbl_miss;
    logic [NUM_REGEX-1:0] tbl_mask;
    logic                 stream_beat;

    assign stream_beat = (state == ST_STREAM) && in_vld;

    dpi_flow_table #(
        .NUM_REGEX    (NUM_REGEX),
        .KEY_W        (KEY_W),
        .DEFAULT_MASK (DEFAULT_MASK)
    ) u_flow_table (
        .clk         (clk),
        .rst         (rst),
        .lookup_en   (state == ST_LOOKUP),
        .lookup_key  (key_q),
        .lookup_id   (tbl_id),
        .lookup_miss (tbl_miss),
        .rd_addr     (lk_id),
        .rd_mask     (tbl_mask),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_mask    (cfg_mask)
    );

    // Next-state, gap counter and ready decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_rdy    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_vld && in_sop) begin
                    state_nxt = ST_LOOKUP;
                end else begin
                    in_rdy = in_vld;
                end
            end
            ST_LOOKUP: state_nxt = ST_LOAD;
            ST_LOAD: begin
                state_nxt = ST_GAP;
                cnt_nxt   = GAP_CNT_W'(LOAD_GAP - 1);
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_STREAM;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_STREAM: begin
                in_rdy = 1'b1;
                if (in_vld && in_eop) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = GAP_CNT_W'(EOP_GAP - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = ST_EOP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_EOP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and gap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Key is held from the sop beat so the lookup sees it the following cycle.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && in_vld && in_sop) begin
            key_q <= in_key;
        end
    end

    // Lookup outcome is parked until LOAD, after the table write settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_id  <= '0;
            lk_new <= 1'b0;
        end else if (state == ST_LOOKUP) begin
            lk_id  <= tbl_id;
            lk_new <= tbl_miss;
        end
    end

    // Registered matcher-facing outputs; stream context only changes in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= '0;
        end else begin
            load_state  <= (state == ST_LOAD);
            eop         <= (state == ST_EOP);
            char_in_vld <= stream_beat;
            char_in     <= stream_beat ? in_data : 8'h00;
            if (state == ST_LOAD) begin
                stream_id     <= lk_id;
                new_stream_id <= lk_new;
                enable        <= tbl_mask;
            end
        end
    end

`ifdef DPI_DISPATCH_STATS_EN
    // Free-running packet and miss counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts <= '0;
            stat_miss <= '0;
        end else begin
            if (state == ST_EOP) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if ((state == ST_LOOKUP) && tbl_miss) begin
                stat_miss <= stat_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dpi_stream_dispatch.sv
// Self-checking bench for dpi_stream_dispatch against a key->slot allocation model.
// Latency: checks exact load/char/eop cycle positions per packet.
// Backpressure: packets are offered back-to-back at minimum spacing.
module tb_dpi_stream_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_vld, in_sop, in_eop;
    logic [31:0] in_key;
    logic        in_rdy;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_mask;
    logic [7:0]  char_in;
    logic        char_in_vld, eop, load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic [7:0]  enable;
`ifdef DPI_DISPATCH_STATS_EN
    logic [31:0] stat_pkts, stat_miss;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dpi_stream_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_vld        (in_vld),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_key        (in_key),
        .in_rdy        (in_rdy),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_mask      (cfg_mask),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .eop           (eop),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .enable        (enable)
`ifdef DPI_DISPATCH_STATS_EN
        ,
        .stat_pkts     (stat_pkts),
        .stat_miss     (stat_miss)
`endif
    );

    // Reference model: key -> slot map, slot owners in allocation order, enable masks.
    int          key2id [logic [31:0]];
    logic [31:0] owner  [64];
    bit          used   [64];
    logic [7:0]  m_mask [64];
    int          next_slot;

    function automatic void model_reset();
        key2id.delete();
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        next_slot = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] k, output int id, output bit is_new);
        if (key2id.exists(k)) begin
            id     = key2id[k];
            is_new = 1'b0;
        end else begin
            id     = next_slot;
            is_new = 1'b1;
            if (used[id]) key2id.delete(owner[id]);
            owner[id]  = k;
            used[id]   = 1'b1;
            key2id[k]  = id;
            m_mask[id] = 8'hFF;
            next_slot  = (next_slot + 1) % 64;
        end
    endfunction

    // Offers one packet starting now (caller sits just after a falling edge) and checks it end to end.
    task automatic send_pkt(input logic [31:0] key, input int len, input int cfg_cyc,
                            input logic [5:0] c_addr, input logic [7:0] c_mask,
                            output int got_id, output bit got_new, output logic [7:0] got_en);
        logic [7:0] bytes [$];
        int exp_id;
        bit exp_new;
        logic [7:0] exp_en;
        int cyc, sent, rcvd, byte_err, rdy_cnt, first_rdy_c, load_c, first_chr_c, last_chr_c, eop_c;
        int loads, eops;
        bit done, hold_ok, wrote;
        logic [5:0] h_id;
        logic h_new;
        logic [7:0] h_en;
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
        model_lookup(key, exp_id, exp_new);
        exp_en = m_mask[exp_id];
        cyc = 0; sent = 0; rcvd = 0; byte_err = 0; rdy_cnt = 0; first_rdy_c = -1;
        load_c = -1; first_chr_c = -1; last_chr_c = -1; eop_c = -1; loads = 0; eops = 0;
        done = 1'b0; hold_ok = 1'b1; h_id = '0; h_new = 1'b0; h_en = '0;
        while (!done && cyc < 60 + len) begin
            if (sent < len) begin
                in_vld  = 1'b1;
                in_sop  = (sent == 0);
                in_eop  = (sent == len - 1);
                in_data = bytes[sent];
                in_key  = (sent == 0) ? key : 32'($urandom);
            end else begin
                in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            end
            cfg_we   = (cyc == cfg_cyc);
            cfg_addr = c_addr;
            cfg_mask = c_mask;
            #1;
            if (in_rdy) begin
                rdy_cnt++;
                if (first_rdy_c < 0) first_rdy_c = cyc;
                if (in_vld) sent++;
            end
            wrote = cfg_we;
            @(negedge clk);
            // A cfg write in the lookup cycle of a freshly allocated slot loses to the allocation.
            if (wrote && !(cyc == 1 && exp_new && c_addr == 6'(exp_id))) m_mask[c_addr] = c_mask;
            cfg_we = 1'b0;
            cyc++;
            if (load_state) begin
                loads++;
                load_c = cyc; h_id = stream_id; h_new = new_stream_id; h_en = enable;
            end else if (load_c >= 0 && (stream_id !== h_id || new_stream_id !== h_new || enable !== h_en)) begin
                hold_ok = 1'b0;
            end
            if (char_in_vld) begin
                if (first_chr_c < 0) first_chr_c = cyc;
                last_chr_c = cyc;
                if (rcvd >= len || char_in !== bytes[rcvd]) byte_err++;
                rcvd++;
            end
            if (eop) begin
                eops++; eop_c = cyc; done = 1'b1;
            end
        end
        got_id = int'(h_id); got_new = h_new; got_en = h_en;

        vectors++;
        if (!done) begin errors++; $display("FAIL eop_timeout: key=%h no eop within %0d cycles", key, cyc); end
        vectors++;
        if (loads != 1) begin errors++; $display("FAIL load_pulses: got %0d exp 1", loads); end
        vectors++;
        if (eops != 1) begin errors++; $display("FAIL eop_pulses: got %0d exp 1", eops); end
        vectors++;
        if (load_c != 3) begin errors++; $display("FAIL sop_to_load: got %0d exp 3", load_c); end
        vectors++;
        if (int'(h_id) != exp_id) begin errors++; $display("FAIL stream_id: key=%h got %0d exp %0d", key, h_id, exp_id); end
        vectors++;
        if (h_new !== exp_new) begin errors++; $display("FAIL new_stream_id: key=%h got %0b exp %0b", key, h_new, exp_new); end
        vectors++;
        if (h_en !== exp_en) begin errors++; $display("FAIL enable: id=%0d got %h exp %h", exp_id, h_en, exp_en); end
        vectors++;
        if (first_chr_c != load_c + 3) begin errors++; $display("FAIL load_to_char: got %0d exp %0d", first_chr_c - load_c, 3); end
        vectors++;
        if (eop_c != last_chr_c + 5) begin errors++; $display("FAIL char_to_eop: got %0d exp %0d", eop_c - last_chr_c, 5); end
        vectors++;
        if (rcvd != len || byte_err != 0) begin errors++; $display("FAIL char_data: got %0d chars %0d bad, exp %0d chars", rcvd, byte_err, len); end
        vectors++;
        if (rdy_cnt != len || first_rdy_c != load_c + 2) begin
            errors++; $display("FAIL in_rdy_window: rdy cycles %0d first %0d, exp %0d first %0d", rdy_cnt, first_rdy_c, len, load_c + 2);
        end
        vectors++;
        if (!hold_ok) begin errors++; $display("FAIL ctx_hold: stream context changed between load_state and eop"); end
        vectors++;
        if (eop_c != len + 10) begin errors++; $display("FAIL sop_spacing: got %0d exp %0d", eop_c, len + 10); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_key = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        vectors++;
        if ({char_in, char_in_vld, eop, load_state, stream_id, new_stream_id, enable, in_rdy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got char=%h v=%b eop=%b ld=%b id=%0d new=%b en=%h rdy=%b exp all 0",
                     char_in, char_in_vld, eop, load_state, stream_id, new_stream_id, enable, in_rdy);
        end
        // A stray non-sop beat in IDLE is swallowed for one cycle and starts nothing.
        in_vld = 1'b1; in_data = 8'h77;
        #1;
        vectors++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL drop_rdy: got %b exp 1", in_rdy); end
        @(negedge clk);
        in_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (load_state !== 1'b0 || char_in_vld !== 1'b0) begin
                errors++; $display("FAIL drop_quiet: got ld=%b cv=%b exp 0 0", load_state, char_in_vld);
            end
        end
    endtask

    task automatic test_new_and_hit();
        int id; bit nw; logic [7:0] en;
        send_pkt(32'hA5A5_0001, 5, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 0 || nw !== 1'b1) begin errors++; $display("FAIL first_alloc: got id=%0d new=%b exp id=0 new=1", id, nw); end
        send_pkt(32'hA5A5_0001, 3, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 0 || nw !== 1'b0) begin errors++; $display("FAIL repeat_hit: got id=%0d new=%b exp id=0 new=0", id, nw); end
        send_pkt(32'hA5A5_0002, 4, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 1 || nw !== 1'b1) begin errors++; $display("FAIL second_alloc: got id=%0d new=%b exp id=1 new=1", id, nw); end
    endtask

    task automatic test_cfg_mask();
        int id; bit nw; logic [7:0] en;
        send_pkt(32'hA5A5_0001, 6, 6, 6'd0, 8'h05, id, nw, en);
        vectors++;
        if (en !== 8'hFF) begin errors++; $display("FAIL cfg_midpkt: got %h exp ff", en); end
        send_pkt(32'hA5A5_0001, 2, -1, '0, '0, id, nw, en);
        vectors++;
        if (en !== 8'h05) begin errors++; $display("FAIL cfg_next_load: got %h exp 05", en); end
        // cfg write to the slot being allocated, in the lookup cycle: allocation wins.
        send_pkt(32'hB000_0001, 2, 1, 6'(next_slot), 8'h3C, id, nw, en);
        send_pkt(32'hB000_0001, 2, -1, '0, '0, id, nw, en);
        vectors++;
        if (en !== 8'hFF) begin errors++; $display("FAIL cfg_alloc_collide: got %h exp ff", en); end
    endtask

    task automatic test_single_and_back_to_back();
        int id; bit nw; logic [7:0] en;
        send_pkt(32'hA5A5_0002, 1, -1, '0, '0, id, nw, en);
        send_pkt(32'hA5A5_0001, 1, -1, '0, '0, id, nw, en);
        send_pkt(32'hA5A5_0002, 7, -1, '0, '0, id, nw, en);
        send_pkt(32'hD00D_0000, 1, -1, '0, '0, id, nw, en);
    endtask

    task automatic test_random_traffic();
        logic [31:0] pool [6];
        int id; bit nw; logic [7:0] en;
        for (int i = 0; i < 6; i++) pool[i] = $urandom;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0)
                send_pkt(pool[$urandom_range(0, 5)], $urandom_range(1, 8), 7, 6'($urandom_range(0, 7)),
                         8'($urandom), id, nw, en);
            else
                send_pkt(pool[$urandom_range(0, 5)], $urandom_range(1, 8), -1, '0, '0, id, nw, en);
        end
    endtask

    task automatic test_reset_mid_stream();
        int acc, eops, loads;
        int id; bit nw; logic [7:0] en;
        acc = 0;
        in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_key = 32'hA5A5_0001; in_data = 8'h11;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            #1;
            if (in_rdy) begin acc++; in_sop = 1'b0; end
            @(negedge clk);
            in_data = 8'($urandom);
        end
        vectors++;
        if (acc != 2) begin errors++; $display("FAIL rst_setup: got %0d beats accepted exp 2", acc); end
        rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0;
        @(negedge clk);
        vectors++;
        if ({char_in, char_in_vld, eop, load_state, stream_id, new_stream_id, enable, in_rdy} !== '0) begin
            errors++;
            $display("FAIL rst_midstream: got char=%h v=%b eop=%b ld=%b id=%0d new=%b en=%h rdy=%b exp all 0",
                     char_in, char_in_vld, eop, load_state, stream_id, new_stream_id, enable, in_rdy);
        end
        rst = 1'b0;
        model_reset();
        eops = 0; loads = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (eop) eops++;
            if (load_state) loads++;
        end
        vectors++;
        if (eops != 0 || loads != 0) begin errors++; $display("FAIL rst_no_eop: got eop=%0d load=%0d exp 0 0", eops, loads); end
        send_pkt(32'hA5A5_0001, 3, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 0 || nw !== 1'b1) begin errors++; $display("FAIL rst_realloc: got id=%0d new=%b exp id=0 new=1", id, nw); end
    endtask

    task automatic test_table_wrap();
        int id; bit nw; logic [7:0] en;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 65; k++) send_pkt(32'hC000_0000 + 32'(k), 1, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 0 || nw !== 1'b1) begin errors++; $display("FAIL wrap_65th: got id=%0d new=%b exp id=0 new=1", id, nw); end
        send_pkt(32'hC000_0000, 2, -1, '0, '0, id, nw, en);
        vectors++;
        if (id != 1 || nw !== 1'b1) begin errors++; $display("FAIL wrap_evicted: got id=%0d new=%b exp id=1 new=1", id, nw); end
    endtask

    initial begin
        test_reset();
        test_new_and_hit();
        test_cfg_mask();
        test_single_and_back_to_back();
        test_random_traffic();
        test_reset_mid_stream();
        test_table_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
